// File: rtl/obuf_mem_rd_stream.sv
// -----------------------------------------------------------------------------
// obuf_mem_rd_stream
//
// Drains the output buffer toward DDR. A command {base address, word count} is
// accepted in IDLE. The block then issues reads on the obuf memory-side read
// port and returns the words, in address order, on a valid/ready stream. A
// small skid FIFO absorbs the fixed memory read latency. Reads are only issued
// while the FIFO plus the reads still in flight have room, so the FIFO can
// never overflow even when the consumer stalls.
//
// Optional feature (macro OBUF_RD_STALL_CNT_EN):
//   Adds output stall_cycles[31:0]. It counts cycles with rd_valid & !rd_ready
//   while a command is active. It clears on command accept, saturates at
//   all-ones and holds its value after done.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_base_addr     first obuf word address
//   cmd_num_words     number of words to read (0 allowed)
//   mem_read_req      obuf read strobe
//   mem_read_addr     obuf read address (wraps modulo 2^ADDR_W)
//   mem_read_data     obuf read data, valid RD_LATENCY cycles after req
//   rd_valid/ready    output stream handshake
//   rd_data, rd_last  stream payload, last marks word num_words-1
//   busy              command active (ISSUE or DRAIN)
//   done              1-cycle completion pulse
//   stall_cycles      (optional) stall counter
// -----------------------------------------------------------------------------
module obuf_mem_rd_stream #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 256,
   parameter int CNT_W      = 16,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base_addr,
   input  logic [CNT_W-1:0]  cmd_num_words,
   output logic              mem_read_req,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic              done
`ifdef OBUF_RD_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CR_W   = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [CNT_W-1:0]    num_words_reg;
   logic [CNT_W-1:0]    issued_reg;
   logic [CNT_W-1:0]    delivered_reg;
   logic [CNT_W-1:0]    last_idx;
   logic [RD_LATENCY-1:0] pipe_reg, pipe_next;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [FCNT_W-1:0]   fifo_count_reg;
   logic [CR_W-1:0]     inflight, credit_used;
   logic                cmd_accept, fifo_wr, fifo_rd, fifo_empty;

   // ---------------------------------------------------------------- control
   assign cmd_ready     = (state_reg == IDLE);
   assign cmd_accept    = cmd_valid && cmd_ready;
   assign busy          = (state_reg == ISSUE) || (state_reg == DRAIN);
   assign done          = (state_reg == DONE);
   assign last_idx      = num_words_reg - {{(CNT_W-1){1'b0}}, 1'b1};
   assign mem_read_addr = addr_reg;

   // Reads in flight: one bit per outstanding request, shifted toward the
   // cycle in which its data is on mem_read_data.
   assign pipe_next[0] = mem_read_req;
   generate
      for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
         assign pipe_next[gi] = pipe_reg[gi-1];
      end
   endgenerate

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CR_W'(pipe_reg[i]);
      end
   end

   // Credit: every in-flight read already owns a FIFO slot.
   assign credit_used  = CR_W'(fifo_count_reg) + inflight;
   assign mem_read_req = (state_reg == ISSUE) && (credit_used < CR_W'(FIFO_DEPTH));

   // ---------------------------------------------------------------- stream
   assign fifo_wr    = pipe_reg[RD_LATENCY-1];
   assign fifo_empty = (fifo_count_reg == '0);
   assign rd_valid   = !fifo_empty;
   assign fifo_rd    = rd_valid && rd_ready;
   // Forced to zero when empty so the output is clean after reset/flush.
   assign rd_data    = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
   assign rd_last    = rd_valid && (delivered_reg == last_idx);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (cmd_accept) state_next = (cmd_num_words != '0) ? ISSUE : DONE;
         ISSUE: if (mem_read_req && (issued_reg == last_idx)) state_next = DRAIN;
         DRAIN: if (fifo_rd && rd_last) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         num_words_reg  <= '0;
         issued_reg     <= '0;
         delivered_reg  <= '0;
         pipe_reg       <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
      end else begin
         state_reg <= state_next;
         pipe_reg  <= pipe_next;
         if (cmd_accept) begin
            addr_reg      <= cmd_base_addr;
            num_words_reg <= cmd_num_words;
            issued_reg    <= '0;
            delivered_reg <= '0;
         end else begin
            if (mem_read_req) begin
               addr_reg   <= addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
               issued_reg <= issued_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (fifo_rd) begin
               delivered_reg <= delivered_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + {{(PTR_W-1){1'b0}}, 1'b1};
         if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + {{(PTR_W-1){1'b0}}, 1'b1};
         case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count_reg <= fifo_count_reg + {{(FCNT_W-1){1'b0}}, 1'b1};
            2'b01:   fifo_count_reg <= fifo_count_reg - {{(FCNT_W-1){1'b0}}, 1'b1};
            default: fifo_count_reg <= fifo_count_reg;
         endcase
      end
   end

   // Storage has no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (fifo_wr) fifo_mem[wr_ptr_reg] <= mem_read_data;
   end

   // The credit rule makes a write into a full FIFO without a read impossible.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(fifo_wr && !fifo_rd && (fifo_count_reg == FCNT_W'(FIFO_DEPTH))));
      end
   end

`ifdef OBUF_RD_STALL_CNT_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if (cmd_accept) begin
         stall_cnt_reg <= '0;
      end else if (busy && rd_valid && !rd_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_obuf_mem_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_obuf_mem_rd_stream
//
// Table of commands {base, count, consumer hold-off} with hand-computed
// expectations (reads issued during the hold-off, last read address), applied
// in a loop, plus hand-written sequences for zero-count, mid-command reset and
// the optional stall counter. The obuf is modelled as a function of the
// address so returned words can be checked for order and loss.
// -----------------------------------------------------------------------------
module tb_obuf_mem_rd_stream;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 256;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_base_addr;
   logic [CNT_W-1:0]  cmd_num_words;
   logic              mem_read_req;
   logic [ADDR_W-1:0] mem_read_addr;
   logic [DATA_W-1:0] mem_read_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              busy;
   logic              done;
`ifdef OBUF_RD_STALL_CNT_EN
   logic [31:0]       stall_cycles;
`endif

   obuf_mem_rd_stream #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .RD_LATENCY(1), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base_addr(cmd_base_addr), .cmd_num_words(cmd_num_words),
      .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
      .mem_read_data(mem_read_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy), .done(done)
`ifdef OBUF_RD_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] w;
      for (int k = 0; k < 8; k++) begin
         logic [7:0] kb;
         kb = k[7:0];
         w[k*32 +: 32] = {kb ^ 8'h5A, 9'h000, a};
      end
      return w;
   endfunction

   // obuf model: one-cycle read latency, junk when not reading
   always @(posedge clk) begin
      if (mem_read_req) mem_read_data <= mem_word(mem_read_addr);
      else              mem_read_data <= {8{32'hBAD0_BAD0}};
   end

   // ---------------------------------------------------------------- monitor
   logic [ADDR_W-1:0] addr_q[$];
   int                addr_cyc_q[$];
   logic [DATA_W-1:0] data_q[$];
   logic              last_q[$];
   int                hs_cyc_q[$];
   int                done_cnt, done_cyc, busy_bad, stab_bad, acc_cyc, valid_seen;
   logic              prev_hold;
   logic [DATA_W-1:0] prev_data;
   logic              prev_last;

   always @(negedge clk) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         if (mem_read_req) begin
            addr_q.push_back(mem_read_addr);
            addr_cyc_q.push_back(cyc);
         end
         if (rd_valid && rd_ready) begin
            data_q.push_back(rd_data);
            last_q.push_back(rd_last);
            hs_cyc_q.push_back(cyc);
         end
         if (rd_valid) valid_seen++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) busy_bad++;
         end
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (prev_hold && (!rd_valid || rd_data !== prev_data || rd_last !== prev_last)) stab_bad++;
         prev_hold = rd_valid && !rd_ready;
         prev_data = rd_data;
         prev_last = rd_last;
      end
   end

   task automatic clear_mon();
      addr_q.delete(); addr_cyc_q.delete(); data_q.delete(); last_q.delete(); hs_cyc_q.delete();
      done_cnt = 0; done_cyc = 0; busy_bad = 0; stab_bad = 0; acc_cyc = 0; valid_seen = 0;
   endtask

   // ---------------------------------------------------------------- checking
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_mem_read_req", mem_read_req, 0);
      check("rst_mem_read_addr", mem_read_addr, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
`ifdef OBUF_RD_STALL_CNT_EN
      check("rst_stall_cycles", stall_cycles, 0);
`endif
   endtask

   task automatic issue_cmd(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] n);
      bit got;
      got = 0;
      cmd_base_addr = base;
      cmd_num_words = n;
      cmd_valid     = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            got = 1;
            break;
         end
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      check("cmd_accepted", got, 1);
   endtask

   task automatic wait_done();
      bit got;
      got = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         if (done_cnt > 0) begin
            got = 1;
            break;
         end
      end
      check("done_within_budget", got, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [ADDR_W-1:0] base;
      logic [CNT_W-1:0]  n;
      int                hold;            // cycles after accept with rd_ready low
      int                exp_hold_reads;  // reads issued by end of hold (hold>0)
      logic [ADDR_W-1:0] exp_last_addr;   // address of final read
   } vec_t;

   task automatic run_cmd(input vec_t v);
      int nw;
      logic [ADDR_W-1:0] a;
      clear_mon();
      rd_ready = (v.hold == 0);
      issue_cmd(v.base, v.n);
      if (v.hold > 0) begin
         // a competing command offered while busy must be ignored
         cmd_base_addr = 15'h5555;
         cmd_num_words = 16'd7;
         cmd_valid     = 1'b1;
         repeat (v.hold) @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         check("reads_during_hold", addr_q.size(), v.exp_hold_reads);
         check("words_during_hold", data_q.size(), 0);
         rd_ready = 1'b1;
      end
      wait_done();
      nw = int'(v.n);
      check("done_count", done_cnt, 1);
      check("reads_issued", addr_q.size(), nw);
      check("words_delivered", data_q.size(), nw);
      if (addr_q.size() > 0) begin
         check("first_addr", addr_q[0], v.base);
         check("last_addr", addr_q[addr_q.size()-1], v.exp_last_addr);
      end
      for (int i = 0; i < addr_q.size() && i < nw; i++) begin
         a = v.base + ADDR_W'(i);
         if (addr_q[i] !== a) check("read_addr_seq", addr_q[i], a);
      end
      for (int i = 0; i < data_q.size() && i < nw; i++) begin
         a = v.base + ADDR_W'(i);
         check($sformatf("word%0d_data", i), data_q[i], mem_word(a));
         check($sformatf("word%0d_last", i), last_q[i], (i == nw - 1));
      end
      if (v.hold == 0 && addr_cyc_q.size() == nw && nw > 0)
         check("reads_back_to_back_span", addr_cyc_q[nw-1] - addr_cyc_q[0], nw - 1);
      if (hs_cyc_q.size() > 0)
         check("done_after_last_hs", done_cyc - hs_cyc_q[hs_cyc_q.size()-1], 1);
      check("busy_low_with_done", busy_bad, 0);
      check("data_stable_under_stall", stab_bad, 0);
      check("idle_busy", busy, 0);
      check("idle_cmd_ready", cmd_ready, 1);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{base: 15'h0010, n: 16'd4,  hold: 0,  exp_hold_reads: 0, exp_last_addr: 15'h0013};
      vecs[1] = '{base: 15'h0000, n: 16'd8,  hold: 10, exp_hold_reads: 4, exp_last_addr: 15'h0007};
      vecs[2] = '{base: 15'h7FFE, n: 16'd4,  hold: 0,  exp_hold_reads: 0, exp_last_addr: 15'h0001};
      vecs[3] = '{base: 15'h0123, n: 16'd1,  hold: 3,  exp_hold_reads: 1, exp_last_addr: 15'h0123};
      vecs[4] = '{base: 15'h0200, n: 16'd20, hold: 2,  exp_hold_reads: 2, exp_last_addr: 15'h0213};

      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_base_addr = '0;
      cmd_num_words = '0;
      rd_ready = 1'b0;
      clear_mon();
      prev_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals();
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

      // zero-count command: no reads, no data, a single done pulse
      clear_mon();
      rd_ready = 1'b1;
      issue_cmd(15'h0040, 16'd0);
      repeat (5) @(posedge clk);
      #1;
      check("zero_reads", addr_q.size(), 0);
      check("zero_rd_valid_cycles", valid_seen, 0);
      check("zero_done_count", done_cnt, 1);
      check("zero_done_latency_ok", (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1);
      check("zero_cmd_ready", cmd_ready, 1);

      // reset in the middle of a 16-word command
      clear_mon();
      rd_ready = 1'b1;
      issue_cmd(15'h0400, 16'd16);
      for (int k = 0; k < 50; k++) begin
         if (addr_q.size() >= 3) break;
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_vals();
      clear_mon();
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_no_valid", valid_seen, 0);
      check("post_rst_no_done", done_cnt, 0);
      check("post_rst_no_reads", addr_q.size(), 0);
      run_cmd('{base: 15'h0100, n: 16'd2, hold: 0, exp_hold_reads: 0, exp_last_addr: 15'h0101});

`ifdef OBUF_RD_STALL_CNT_EN
      // stall counter: consumer holds off 5 cycles while rd_valid is high
      clear_mon();
      rd_ready = 1'b0;
      issue_cmd(15'h0050, 16'd4);
      for (int k = 0; k < 20; k++) begin
         if (rd_valid) break;
         @(posedge clk);
         #1;
      end
      check("stall_rd_valid_seen", rd_valid, 1);
      repeat (5) @(posedge clk);
      #1 rd_ready = 1'b1;
      wait_done();
      check("stall_cycles_value", stall_cycles, 5);
      repeat (4) @(posedge clk);
      #1;
      check("stall_cycles_held", stall_cycles, 5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
